// File: rtl/fm_pkg.sv
// Shared FM-radio DSP definitions: sample type and FIFO sizing helper.
package fm_pkg;

    localparam int SAMPLE_WIDTH = 32;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    // Occupancy counters need one bit more than the address to represent DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO between adjacent DSP stages.
// Optional sticky overflow/underflow flags are built when SAMPLE_FIFO_ERR_EN is defined.
module sample_fifo
    import fm_pkg::*;
#(
    parameter int DATA_WIDTH = SAMPLE_WIDTH,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic                        full,
    output logic                        almost_full,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        empty,
`ifdef SAMPLE_FIFO_ERR_EN
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        err_clr,
`endif
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  push, pop;

    // Flags come from registered pointers only, so requests never reach them combinationally.
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count       = wr_ptr_q - rd_ptr_q;
    assign almost_full = (count >= PW'(AF_LEVEL));

    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);

    // Stale storage is masked while empty so dout reads zero after reset.
    assign dout = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

`ifdef SAMPLE_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error on the clearing edge keeps the flag set.
    assign overflow_d  = (wr_en && full)  || (overflow_q  && !err_clr);
    assign underflow_d = (rd_en && empty) || (underflow_q && !err_clr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench for sample_fifo: queue-based reference model compared every cycle
// plus directed literal checks for the documented scenarios.
module tb_sample_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din   = '0;
    logic          rd_en = 1'b0;
    logic          full, almost_full, empty;
    logic [DW-1:0] dout;
    logic [4:0]    count;
`ifdef SAMPLE_FIFO_ERR_EN
    logic          overflow, underflow;
    logic          err_clr = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit seen77   = 1'b0;

    sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .din         (din),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .dout        (dout),
        .empty       (empty),
`ifdef SAMPLE_FIFO_ERR_EN
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr),
`endif
        .count       (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO contents as a plain queue.
    logic [DW-1:0] q [$];
`ifdef SAMPLE_FIFO_ERR_EN
    bit m_ovf = 1'b0, m_unf = 1'b0;
`endif

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
`ifdef SAMPLE_FIFO_ERR_EN
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
`endif
        end else begin
`ifdef SAMPLE_FIFO_ERR_EN
            m_ovf <= (wr_en && q.size() == DEPTH) || (m_ovf && !err_clr);
            m_unf <= (rd_en && q.size() == 0)     || (m_unf && !err_clr);
`endif
            if (rd_en && q.size() != 0) begin
                if (wr_en && q.size() != DEPTH) q.push_back(din);
                void'(q.pop_front());
            end else if (wr_en && q.size() != DEPTH) begin
                q.push_back(din);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("model_count", 64'(count), 64'(q.size()));
            check("model_empty", 64'(empty), 64'(q.size() == 0));
            check("model_full",  64'(full),  64'(q.size() == DEPTH));
            check("model_af",    64'(almost_full), 64'(q.size() >= AFL));
            if (q.size() != 0) check("model_dout", 64'(dout), 64'(q[0]));
`ifdef SAMPLE_FIFO_ERR_EN
            check("model_ovf", 64'(overflow),  64'(m_ovf));
            check("model_unf", 64'(underflow), 64'(m_unf));
`endif
            if (!empty && dout == 32'h77) seen77 <= 1'b1;
        end
    end

    // Present one cycle of requests, then look at the state 1 time unit after the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset
        #2 reset = 1'b1;
        #10;
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full",  64'(full),  64'd0);
        check("rst_af",    64'(almost_full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_dout",  64'(dout),  64'd0);
        @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(posedge clock);
        #1;

        // 1: fill with 0x1..0x10
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, DW'(i), 1'b0);
            if (i == 11) check("af_at_11", 64'(almost_full), 64'd0);
            if (i == 12) check("af_at_12", 64'(almost_full), 64'd1);
            if (i == 15) check("full_at_15", 64'(full), 64'd0);
        end
        check("fill_full",  64'(full),  64'd1);
        check("fill_count", 64'(count), 64'd16);
        step(1'b1, 32'hFF, 1'b0);
        check("ovf_push_count", 64'(count), 64'd16);
        check("ovf_push_head",  64'(dout),  64'h1);
`ifdef SAMPLE_FIFO_ERR_EN
        check("overflow_set", 64'(overflow), 64'd1);
`endif

        // 2: drain in order
        for (int i = 1; i <= 16; i++) begin
            check("drain_dout", 64'(dout), 64'(i));
            step(1'b0, '0, 1'b1);
        end
        check("drain_empty", 64'(empty), 64'd1);
        step(1'b0, '0, 1'b1);
        check("unf_pop_count", 64'(count), 64'd0);
`ifdef SAMPLE_FIFO_ERR_EN
        check("underflow_set", 64'(underflow), 64'd1);
        err_clr = 1'b1;
        step(1'b0, '0, 1'b0);
        err_clr = 1'b0;
        check("clr_ovf", 64'(overflow),  64'd0);
        check("clr_unf", 64'(underflow), 64'd0);
        // clear together with a new underflow: the error wins
        err_clr = 1'b1;
        step(1'b0, '0, 1'b1);
        err_clr = 1'b0;
        check("clr_vs_new_unf", 64'(underflow), 64'd1);
        err_clr = 1'b1;
        step(1'b0, '0, 1'b0);
        err_clr = 1'b0;
`endif

        // 3: single push on empty, no same-cycle bypass
        check("fwft_empty_N", 64'(empty), 64'd1);
        wr_en = 1'b1;
        din   = 32'hABCD;
        #1 check("fwft_no_bypass", 64'(empty), 64'd1);
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        check("fwft_empty_N1", 64'(empty), 64'd0);
        check("fwft_dout_N1",  64'(dout),  64'hABCD);
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'h55, 1'b1);
        check("pp_empty_count", 64'(count), 64'd1);
        check("pp_empty_dout",  64'(dout),  64'h55);
        step(1'b0, '0, 1'b1);

        // 4: steady state at count 5 across the wrap
        for (int i = 0; i < 5; i++) step(1'b1, DW'(32'h200 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, DW'(32'h300 + i), 1'b1);
            check("steady_count", 64'(count), 64'd5);
        end
        check("steady_head", 64'(dout), 64'h323);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        check("steady_drained", 64'(empty), 64'd1);

        // 5: push+pop on full drops the push
        for (int i = 0; i < 16; i++) step(1'b1, DW'(32'h400 + i), 1'b0);
        step(1'b1, 32'h77, 1'b1);
        check("full_pp_count", 64'(count), 64'd15);
        check("full_pp_head",  64'(dout),  64'h401);
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
        @(negedge clock);
        #1;
        check("no_77_seen", 64'(seen77), 64'd0);
`ifdef SAMPLE_FIFO_ERR_EN
        err_clr = 1'b1;
        step(1'b0, '0, 1'b0);
        err_clr = 1'b0;
`endif

        // 6: asynchronous reset mid-stream
        @(posedge clock);
        #1;
        for (int i = 0; i < 9; i++) step(1'b1, DW'(32'h500 + i), 1'b0);
        check("pre_rst_count", 64'(count), 64'd9);
        #2 reset = 1'b1;
        #1;
        check("async_rst_empty", 64'(empty), 64'd1);
        check("async_rst_count", 64'(count), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        step(1'b1, 32'h5, 1'b0);
        check("post_rst_dout",  64'(dout),  64'h5);
        check("post_rst_count", 64'(count), 64'd1);
        step(1'b0, '0, 1'b1);
        repeat (2) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
